// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the memory-stage data-bus access controller.
package mem_access_ctrl_pkg;

    localparam int unsigned DBUS_XLEN   = 64;
    localparam int unsigned DBUS_STRB_W = DBUS_XLEN / 8;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } mem_acc_state_t;

    typedef struct packed {
        logic                   valid;
        logic [DBUS_XLEN-1:0]   addr;
        logic [2:0]             size;
        logic [DBUS_STRB_W-1:0] strobe;
        logic [DBUS_XLEN-1:0]   data;
    } dbus_req_t;

    typedef struct packed {
        logic                 addr_ok;
        logic                 data_ok;
        logic [DBUS_XLEN-1:0] data;
    } dbus_resp_t;

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] byte_mask(msize_t sz);
        case (sz)
            MSIZE1:  return 8'h01;
            MSIZE2:  return 8'h03;
            MSIZE4:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(msize_t sz);
        case (sz)
            MSIZE1:  return 3'b000;
            MSIZE2:  return 3'b001;
            MSIZE4:  return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Take the low size bytes of v and zero- or sign-extend them.
    function automatic logic [DBUS_XLEN-1:0] ext_load(logic [DBUS_XLEN-1:0] v, msize_t sz, logic uns);
        case (sz)
            MSIZE1:  return uns ? {{(DBUS_XLEN-8){1'b0}}, v[7:0]}   : {{(DBUS_XLEN-8){v[7]}}, v[7:0]};
            MSIZE2:  return uns ? {{(DBUS_XLEN-16){1'b0}}, v[15:0]} : {{(DBUS_XLEN-16){v[15]}}, v[15:0]};
            MSIZE4:  return uns ? {{(DBUS_XLEN-32){1'b0}}, v[31:0]} : {{(DBUS_XLEN-32){v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// mem_align_unit: combinational byte-lane alignment for stores and loads.
module mem_align_unit
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STRB_W = XLEN / 8,
    parameter int unsigned OFF_W  = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  st_off,
    input  msize_t            st_size,
    input  logic [XLEN-1:0]   st_wdata,
    output logic [STRB_W-1:0] st_strobe,
    output logic [XLEN-1:0]   st_data,
    input  logic [OFF_W-1:0]  ld_off,
    input  msize_t            ld_size,
    input  logic              ld_unsigned,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data
);

    logic [XLEN-1:0] ld_shifted;

    // Store side: move the enable pattern and data into the addressed byte lanes.
    always_comb begin
        st_strobe = STRB_W'(byte_mask(st_size)) << st_off;
        st_data   = st_wdata << {st_off, 3'b000};
    end

    // Load side: bring the addressed bytes down to lane 0, then extend.
    always_comb begin
        ld_shifted = ld_rdata >> {ld_off, 3'b000};
        ld_data    = ext_load(ld_shifted, ld_size, ld_unsigned);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences the memory stage's dbus port for loads/stores.
// Optional macro MEM_ACCESS_PERF_EN adds access and stall-cycle counters.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_valid,
    input  logic              acc_write,
    input  logic [1:0]        acc_size,
    input  logic              acc_unsigned,
    input  logic [XLEN-1:0]   acc_addr,
    input  logic [XLEN-1:0]   acc_wdata,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [XLEN-1:0]   dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [STRB_W-1:0] dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output logic [XLEN-1:0]   memout,
    output logic              stall,
    output logic              done,
    output logic              misalign
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0]       perf_acc_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned OFF_W = $clog2(STRB_W);

    mem_acc_state_t    state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    msize_t            size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic              write_q, write_d;
    logic [STRB_W-1:0] strobe_q, strobe_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              flush_pend_q, flush_pend_d;
    logic [XLEN-1:0]   memout_q, memout_d;

    msize_t            acc_size_e;
    logic              acc_misalign;
    logic              acc_go;
    logic [STRB_W-1:0] st_strobe;
    logic [XLEN-1:0]   st_data;
    logic [XLEN-1:0]   ld_data;

    mem_align_unit #(
        .XLEN   (XLEN),
        .STRB_W (STRB_W)
    ) u_align (
        .st_off      (acc_addr[OFF_W-1:0]),
        .st_size     (acc_size_e),
        .st_wdata    (acc_wdata),
        .st_strobe   (st_strobe),
        .st_data     (st_data),
        .ld_off      (addr_q[OFF_W-1:0]),
        .ld_size     (size_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (dresp_data),
        .ld_data     (ld_data)
    );

    // Next-state and request-capture logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        write_d      = write_q;
        strobe_d     = strobe_q;
        data_d       = data_q;
        flush_pend_d = flush_pend_q;
        memout_d     = memout_q;

        acc_size_e   = msize_t'(acc_size);
        acc_misalign = |(acc_addr[2:0] & align_mask(acc_size_e));
        acc_go       = acc_valid && !acc_misalign && !flush;

        case (state_q)
            S_IDLE: begin
                if (acc_go) begin
                    state_d      = S_REQ;
                    addr_d       = acc_addr;
                    size_d       = acc_size_e;
                    unsigned_d   = acc_unsigned;
                    write_d      = acc_write;
                    strobe_d     = acc_write ? st_strobe : '0;
                    data_d       = st_data;
                    flush_pend_d = 1'b0;
                end
            end
            S_REQ: begin
                // Once accepted the bus transaction must run to data_ok even if flushed.
                if (dresp_addr_ok && dresp_data_ok) begin
                    flush_pend_d = 1'b0;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        if (!write_q) memout_d = ld_data;
                    end
                end else if (dresp_addr_ok) begin
                    state_d      = S_WAIT;
                    flush_pend_d = flush;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    flush_pend_d = 1'b0;
                    if (flush || flush_pend_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        if (!write_q) memout_d = ld_data;
                    end
                end else begin
                    flush_pend_d = flush_pend_q | flush;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        dreq_valid  = (state_q == S_REQ);
        dreq_addr   = addr_q;
        dreq_size   = {1'b0, size_q};
        dreq_strobe = strobe_q;
        dreq_data   = data_q;
        memout      = memout_q;
        done        = (state_q == S_DONE);
        stall       = (state_q == S_REQ) || (state_q == S_WAIT) || ((state_q == S_IDLE) && acc_go);
        misalign    = (state_q == S_IDLE) && acc_valid && acc_misalign;
    end

    // State and captured request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            size_q       <= MSIZE1;
            unsigned_q   <= 1'b0;
            write_q      <= 1'b0;
            strobe_q     <= '0;
            data_q       <= '0;
            flush_pend_q <= 1'b0;
            memout_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            write_q      <= write_d;
            strobe_q     <= strobe_d;
            data_q       <= data_d;
            flush_pend_q <= flush_pend_d;
            memout_q     <= memout_d;
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] perf_acc_cnt_q, perf_acc_cnt_d;
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    // Free-running counters of completed accesses and stalled cycles.
    always_comb begin
        perf_acc_cnt_d   = perf_acc_cnt_q + (done ? 32'd1 : 32'd0);
        perf_stall_cnt_d = perf_stall_cnt_q + (stall ? 32'd1 : 32'd0);
        perf_acc_cnt     = perf_acc_cnt_q;
        perf_stall_cnt   = perf_stall_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_acc_cnt_q   <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_acc_cnt_q   <= perf_acc_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a load-result scoreboard.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        acc_valid;
    logic        acc_write;
    logic [1:0]  acc_size;
    logic        acc_unsigned;
    logic [63:0] acc_addr;
    logic [63:0] acc_wdata;
    logic        flush;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic [63:0] memout;
    logic        stall;
    logic        done;
    logic        misalign;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] perf_acc_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_memout;

    mem_access_ctrl #(
        .XLEN   (64),
        .STRB_W (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .acc_valid     (acc_valid),
        .acc_write     (acc_write),
        .acc_size      (acc_size),
        .acc_unsigned  (acc_unsigned),
        .acc_addr      (acc_addr),
        .acc_wdata     (acc_wdata),
        .flush         (flush),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .memout        (memout),
        .stall         (stall),
        .done          (done),
        .misalign      (misalign)
`ifdef MEM_ACCESS_PERF_EN
        ,
        .perf_acc_cnt  (perf_acc_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 64'hA5A5_A5A5_A5A5_A5A5;
    endtask

    // Waits (bounded) for the done pulse; pops the expected load result if any.
    task automatic wait_done(input string tag, input bit is_load);
        int unsigned k;
        logic [63:0] exp;
        k = 0;
        smp();
        while (done !== 1'b1 && k < 8) begin
            cyc();
            smp();
            k++;
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_stall_done"}, {63'd0, stall}, 64'd0);
        if (is_load) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            chk({tag, "_memout"}, memout, exp);
            last_memout = exp;
        end
    endtask

    // Zero-wait load: IDLE -> REQ (addr_ok+data_ok) -> DONE.
    task automatic do_load(input string tag, input logic [63:0] a, input logic [1:0] sz,
                           input logic uns, input logic [63:0] rd, input logic [63:0] exp);
        acc_valid = 1'b1; acc_write = 1'b0; acc_size = sz; acc_unsigned = uns;
        acc_addr = a; acc_wdata = '0;
        exp_q.push_back(exp);
        smp();
        chk({tag, "_stall_idle"}, {63'd0, stall}, 64'd1);
        cyc();
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = rd;
        smp();
        chk({tag, "_dreq_valid"}, {63'd0, dreq_valid}, 64'd1);
        chk({tag, "_dreq_addr"}, dreq_addr, a);
        chk({tag, "_dreq_strobe"}, {56'd0, dreq_strobe}, 64'd0);
        cyc();
        acc_valid = 1'b0;
        bus_idle();
        wait_done(tag, 1'b1);
        cyc();
    endtask

    initial begin
        reset = 1'b0; acc_valid = 1'b0; acc_write = 1'b0; acc_size = 2'd0;
        acc_unsigned = 1'b0; acc_addr = '0; acc_wdata = '0; flush = 1'b0;
        last_memout = '0;
        bus_idle();

        // Reset state
        repeat (2) smp();
        chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_memout", memout, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_misalign", {63'd0, misalign}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // Loads with various sizes, offsets and extension
        do_load("ld",  64'h1000, 2'd3, 1'b0, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211);
        smp();
        chk("ld_done_clear", {63'd0, done}, 64'd0);
        cyc();
        do_load("lb",  64'h1003, 2'd0, 1'b0, 64'h0000_0000_80FF_FFFF, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 64'h1003, 2'd0, 1'b1, 64'h0000_0000_80FF_FFFF, 64'h0000_0000_0000_0080);
        do_load("lh",  64'h1006, 2'd1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_1234);
        do_load("lw",  64'h1004, 2'd2, 1'b0, 64'hF000_0000_1111_1111, 64'hFFFF_FFFF_F000_0000);
        do_load("lwu", 64'h1004, 2'd2, 1'b1, 64'hF000_0000_1111_1111, 64'h0000_0000_F000_0000);

        // SH with addr_ok delayed 3 cycles: request fields must hold
        acc_valid = 1'b1; acc_write = 1'b1; acc_size = 2'd1; acc_unsigned = 1'b0;
        acc_addr = 64'h2006; acc_wdata = 64'h0000_0000_0000_ABCD;
        cyc();
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("sh_dreq_valid", {63'd0, dreq_valid}, 64'd1);
            chk("sh_dreq_addr", dreq_addr, 64'h2006);
            chk("sh_dreq_size", {61'd0, dreq_size}, 64'd1);
            chk("sh_dreq_strobe", {56'd0, dreq_strobe}, 64'hC0);
            chk("sh_dreq_data", dreq_data, 64'hABCD_0000_0000_0000);
            chk("sh_stall", {63'd0, stall}, 64'd1);
            cyc();
            acc_addr = 64'hFFFF_FFF8; acc_wdata = '1; acc_size = 2'd3;
        end
        dresp_addr_ok = 1'b1;
        smp();
        chk("sh_dreq_strobe_acc", {56'd0, dreq_strobe}, 64'hC0);
        cyc();
        dresp_addr_ok = 1'b0;
        smp();
        chk("sh_wait_valid", {63'd0, dreq_valid}, 64'd0);
        chk("sh_wait_stall", {63'd0, stall}, 64'd1);
        cyc();
        dresp_data_ok = 1'b1;
        smp();
        cyc();
        acc_valid = 1'b0;
        bus_idle();
        wait_done("sh", 1'b0);
        cyc();

        // Misaligned LW
        acc_valid = 1'b1; acc_write = 1'b0; acc_size = 2'd2; acc_addr = 64'h1002;
        smp();
        chk("lw_mis_misalign", {63'd0, misalign}, 64'd1);
        chk("lw_mis_stall", {63'd0, stall}, 64'd0);
        chk("lw_mis_valid", {63'd0, dreq_valid}, 64'd0);
        cyc();
        smp();
        chk("lw_mis_valid2", {63'd0, dreq_valid}, 64'd0);
        cyc();
        acc_valid = 1'b0;

        // Flush after addr_ok: transaction completes silently
        acc_valid = 1'b1; acc_size = 2'd3; acc_addr = 64'h3000;
        cyc();
        dresp_addr_ok = 1'b1;
        smp();
        chk("fl_req_valid", {63'd0, dreq_valid}, 64'd1);
        cyc();
        dresp_addr_ok = 1'b0; flush = 1'b1; acc_valid = 1'b0;
        smp();
        chk("fl_c2_stall", {63'd0, stall}, 64'd1);
        chk("fl_c2_done", {63'd0, done}, 64'd0);
        cyc();
        flush = 1'b0;
        smp();
        chk("fl_c3_stall", {63'd0, stall}, 64'd1);
        chk("fl_c3_done", {63'd0, done}, 64'd0);
        cyc();
        dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_CAFE_F00D;
        smp();
        chk("fl_c4_stall", {63'd0, stall}, 64'd1);
        chk("fl_c4_done", {63'd0, done}, 64'd0);
        cyc();
        bus_idle();
        smp();
        chk("fl_c5_done", {63'd0, done}, 64'd0);
        chk("fl_c5_stall", {63'd0, stall}, 64'd0);
        chk("fl_c5_memout", memout, last_memout);
        cyc();

        // Flush in REQ before addr_ok drops the request
        acc_valid = 1'b1; acc_size = 2'd3; acc_addr = 64'h3008;
        cyc();
        flush = 1'b1; acc_valid = 1'b0;
        smp();
        chk("flr_valid", {63'd0, dreq_valid}, 64'd1);
        cyc();
        flush = 1'b0;
        smp();
        chk("flr_valid_drop", {63'd0, dreq_valid}, 64'd0);
        chk("flr_stall", {63'd0, stall}, 64'd0);
        chk("flr_done", {63'd0, done}, 64'd0);
        cyc();

        // Reset asserted while in WAIT
        acc_valid = 1'b1; acc_size = 2'd3; acc_addr = 64'h5000;
        cyc();
        dresp_addr_ok = 1'b1;
        cyc();
        dresp_addr_ok = 1'b0; acc_valid = 1'b0;
        smp();
        chk("rw_wait_stall", {63'd0, stall}, 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("rw_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rw_stall", {63'd0, stall}, 64'd0);
        chk("rw_memout", memout, 64'd0);
        last_memout = '0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();

        // SD after reset completes normally
        acc_valid = 1'b1; acc_write = 1'b1; acc_size = 2'd3; acc_addr = 64'h4008;
        acc_wdata = 64'h0123_4567_89AB_CDEF;
        cyc();
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
        smp();
        chk("sd_valid", {63'd0, dreq_valid}, 64'd1);
        chk("sd_strobe", {56'd0, dreq_strobe}, 64'hFF);
        chk("sd_data", dreq_data, 64'h0123_4567_89AB_CDEF);
        chk("sd_size", {61'd0, dreq_size}, 64'd3);
        cyc();
        acc_valid = 1'b0;
        bus_idle();
        wait_done("sd", 1'b0);
        cyc();

        // Back-to-back load straight after a store
        do_load("ld2", 64'h6010, 2'd3, 1'b0, 64'hCAFE_BABE_0000_0001, 64'hCAFE_BABE_0000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
